// File: rtl/loop_player.sv
// Single-clock audio looper: records, loops and mixes samples through a block RAM.
// Define LOOPER_OVERDUB_EN to add the OVERDUB state with read-modify-write mixing.
module loop_player #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 30000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       sample_valid_in,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       record_in,
    input  logic                       play_in,
    input  logic                       clear_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid_out,
    output logic [$clog2(DEPTH+1)-1:0] loop_len_out,
    output logic [1:0]                 state_out,
    output logic                       full_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECORD  = 2'd1,
        PLAY    = 2'd2,
        OVERDUB = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q1, rd_q2;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    loop_len;

    logic             v1, v2, mix1, mix2;
    logic [WIDTH-1:0] d1, d2;
    logic [WIDTH-1:0] mix;

    logic             rec_wr;
    logic             rd_last;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

`ifdef LOOPER_OVERDUB_EN
    logic          ovd1, ovd2;
    logic [AW-1:0] a1, a2;
`endif

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat_add = s[WIDTH-1:0];
    endfunction

    assign state_out    = state;
    assign loop_len_out = loop_len;
    assign full_out     = (loop_len == LEN_MAX);

    assign rec_wr  = (state == RECORD) && sample_valid_in && !clear_in && (loop_len != LEN_MAX);
    assign rd_last = (LW'(rd_ptr) == loop_len - LW'(1));
    assign mix     = sat_add(d2, rd_q2);

    always_comb begin
        state_next = state;
        if (clear_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   if (record_in) state_next = RECORD;
                RECORD: begin
                    if (loop_len == LEN_MAX)
                        state_next = PLAY;
                    else if (!record_in)
                        state_next = (loop_len != '0) ? PLAY : IDLE;
                end
`ifdef LOOPER_OVERDUB_EN
                PLAY:    if (record_in && play_in) state_next = OVERDUB;
                OVERDUB: if (!(record_in && play_in)) state_next = PLAY;
`else
                PLAY:    state_next = PLAY;
                default: state_next = IDLE;
`endif
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            loop_len <= '0;
        end else if (clear_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            loop_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    loop_len <= '0;
                end
                RECORD: begin
                    // Holding the read pointer here guarantees playback starts at sample 0.
                    rd_ptr <= '0;
                    if (rec_wr) begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        loop_len <= loop_len + LW'(1);
                    end
                end
                default: begin
                    if (sample_valid_in && play_in && loop_len != '0)
                        rd_ptr <= rd_last ? '0 : rd_ptr + AW'(1);
                end
            endcase
        end
    end

    // Three-stage strobe pipeline; the mix decision is frozen at the strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v1             <= 1'b0;
            v2             <= 1'b0;
            mix1           <= 1'b0;
            mix2           <= 1'b0;
            d1             <= '0;
            d2             <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
`ifdef LOOPER_OVERDUB_EN
            ovd1 <= 1'b0;
            ovd2 <= 1'b0;
            a1   <= '0;
            a2   <= '0;
`endif
        end else begin
            v1 <= sample_valid_in;
            if (sample_valid_in) begin
                d1   <= data_in;
                mix1 <= ((state == PLAY) || (state == OVERDUB)) && play_in;
`ifdef LOOPER_OVERDUB_EN
                ovd1 <= (state == OVERDUB) && play_in;
                a1   <= rd_ptr;
`endif
            end
            v2   <= v1;
            d2   <= d1;
            mix2 <= mix1;
`ifdef LOOPER_OVERDUB_EN
            ovd2 <= ovd1;
            a2   <= a1;
`endif
            data_valid_out <= v2;
            if (v2)
                data_out <= mix2 ? mix : d2;
        end
    end

    always_comb begin
        wr_en   = rec_wr;
        wr_addr = wr_ptr;
        wr_data = data_in;
`ifdef LOOPER_OVERDUB_EN
        if (v2 && ovd2) begin
            wr_en   = 1'b1;
            wr_addr = a2;
            wr_data = mix;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q1 <= mem[rd_ptr];
        rd_q2 <= rd_q1;
    end

endmodule

// File: tb/tb_loop_player.sv
// Scoreboard bench for loop_player (DEPTH=8, WIDTH=16, one strobe every 8 cycles).
module tb_loop_player;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               record = 1'b0;
    logic               play = 1'b0;
    logic               clear = 1'b0;
    logic signed [15:0] data_out;
    logic               data_valid;
    logic [3:0]         loop_len;
    logic [1:0]         state;
    logic               full;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic signed [15:0] val;
        int                 t;
    } exp_t;
    exp_t q[$];

    loop_player #(.WIDTH(16), .DEPTH(8)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .sample_valid_in (sample_valid),
        .data_in         (data_in),
        .record_in       (record),
        .play_in         (play),
        .clear_in        (clear),
        .data_out        (data_out),
        .data_valid_out  (data_valid),
        .loop_len_out    (loop_len),
        .state_out       (state),
        .full_out        (full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] din, input logic signed [15:0] exp,
                        input bit track);
        exp_t e;
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        data_in      = din;
        e.val = exp;
        e.t   = cyc;
        if (track) q.push_back(e);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && data_valid) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data", int'(data_out), int'(e.val));
                check("latency", cyc, e.t + 3);
            end
        end
    end

    initial begin
        // reset state
        wait_cyc(3);
        check("rst_state", state, 0);
        check("rst_len", loop_len, 0);
        check("rst_full", full, 0);
        check("rst_dout", int'(data_out), 0);
        check("rst_valid", data_valid, 0);
        rst = 1'b0;
        wait_cyc(2);

        // record 1,2,3
        record = 1'b1;
        wait_cyc(2);
        check("rec_state", state, 1);
        send(16'sd1, 16'sd1, 1'b1);
        send(16'sd2, 16'sd2, 1'b1);
        send(16'sd3, 16'sd3, 1'b1);
        record = 1'b0;
        wait_cyc(3);
        check("rec_len", loop_len, 3);
        check("rec_to_play", state, 2);
        check("rec_full", full, 0);

        // playback with wrap
        play = 1'b1;
        for (int i = 0; i < 6; i++)
            send(16'sd0, 16'(i % 3 + 1), 1'b1);

        // pause holds pointer, then mixing resumes at sample 0
        play = 1'b0;
        send(16'sd5, 16'sd5, 1'b1);
        play = 1'b1;
        send(16'sd0, 16'sd1, 1'b1);
        send(16'sd100, 16'sd102, 1'b1);
        send(16'sd7, 16'sd10, 1'b1);

        // clear
        clear = 1'b1;
        wait_cyc(2);
        check("clr_state", state, 0);
        check("clr_len", loop_len, 0);
        clear = 1'b0;
        send(16'sd42, 16'sd42, 1'b1);

        // saturation
        record = 1'b1;
        wait_cyc(2);
        send(16'sd30000, 16'sd30000, 1'b1);
        send(-16'sd30000, -16'sd30000, 1'b1);
        record = 1'b0;
        wait_cyc(3);
        check("sat_state", state, 2);
        send(16'sd2767, 16'sd32767, 1'b1);
        send(-16'sd2768, -16'sd32768, 1'b1);
        send(16'sd10000, 16'sd32767, 1'b1);
        send(-16'sd10000, -16'sd32768, 1'b1);
        send(-16'sd1, 16'sd29999, 1'b1);

        // full: eight samples with record held, ninth must not be stored
        clear = 1'b1;
        wait_cyc(2);
        clear = 1'b0;
        play   = 1'b0;
        record = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 8; i++)
            send(16'(11 + i), 16'(11 + i), 1'b1);
        check("full_flag", full, 1);
        check("full_state", state, 2);
        check("full_len", loop_len, 8);
        send(16'sd99, 16'sd99, 1'b1);
        check("full_hold_state", state, 2);
        record = 1'b0;
        play   = 1'b1;
        for (int i = 0; i < 9; i++)
            send(16'sd0, 16'(11 + (i % 8)), 1'b1);

        // async reset mid-PLAY with a strobe in flight
        check("pre_rst_state", state, 2);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        data_in      = 16'sd5;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_len", loop_len, 0);
        check("arst_full", full, 0);
        check("arst_dout", int'(data_out), 0);
        check("arst_valid", data_valid, 0);
        wait_cyc(3);
        rst = 1'b0;
        play = 1'b0;
        wait_cyc(6);

`ifdef LOOPER_OVERDUB_EN
        record = 1'b1;
        wait_cyc(2);
        send(16'sd1, 16'sd1, 1'b1);
        send(16'sd2, 16'sd2, 1'b1);
        send(16'sd3, 16'sd3, 1'b1);
        record = 1'b0;
        play   = 1'b1;
        wait_cyc(3);
        record = 1'b1;
        wait_cyc(2);
        check("ovd_state", state, 3);
        for (int i = 0; i < 3; i++)
            send(16'sd10, 16'(11 + i), 1'b1);
        record = 1'b0;
        wait_cyc(2);
        check("ovd_exit", state, 2);
        for (int i = 0; i < 3; i++)
            send(16'sd0, 16'(11 + i), 1'b1);
`endif

        wait_cyc(4);
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1);
    end

endmodule
